// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared definitions for the router blocks. It holds the default
//               data and FIFO geometry and the header byte field layout
//               (length in bits 7:2, destination address in bits 1:0). It also
//               holds a helper that turns a header byte into the number of
//               bytes that still follow it in the packet.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int C_WIDTH    = 8;   // data byte width
    localparam int C_DEPTH    = 16;  // FIFO words, power of two
    localparam int C_LEN_MSB  = 7;   // header payload-length field
    localparam int C_LEN_LSB  = 2;
    localparam int C_ADDR_MSB = 1;   // header destination-address field
    localparam int C_ADDR_LSB = 0;
    localparam int C_CNT_W    = 7;   // packet byte counter width

    // Bytes that follow a header: the payload length plus one parity byte.
    function automatic logic [C_CNT_W-1:0] pkt_bytes(input logic [C_LEN_MSB:0] hdr);
        return {1'b0, hdr[C_LEN_MSB:C_LEN_LSB]} + 7'd1;
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : Packet FIFO for the router. Each word holds {header_flag, byte}.
//               Read data is registered with a latency of one clock. A packet
//               byte counter tracks how many bytes of the current packet are
//               still to be read. Once the counter is exhausted and the FIFO
//               is idle, the output bus is released to high impedance.
// Ports       : clock      - rising-edge clock
//               resetn     - asynchronous active-low reset
//               soft_reset - synchronous flush (packet timeout)
//               write_enb  - write request (ignored while full)
//               read_enb   - read request (ignored while empty)
//               lfd_state  - data_in is a header byte
//               data_in    - byte to store
//               data_out   - registered read byte, tri-stateable
//               full/empty - occupancy flags, combinational from the pointers
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int DEPTH = C_DEPTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output wire  [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH:0]         mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]       dout_q, dout_d;
    logic                   oe_q, oe_d;
    logic                   do_wr, do_rd;
    logic [WIDTH:0]         rd_word;

    // The extra pointer MSB separates a wrapped-around full FIFO from an empty one.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_wr   = write_enb && !full;
    assign do_rd   = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    assign data_out = oe_q ? dout_q : {WIDTH{1'bz}};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = rd_word[WIDTH-1:0];
            oe_d     = 1'b1;
            if (rd_word[WIDTH]) begin
                cnt_d = pkt_bytes(rd_word[C_LEN_MSB:0]);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (cnt_q == '0) begin
            // Packet fully drained and nothing read: release the bus.
            oe_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b1;   // bus driven low while in reset
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (soft_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            if (do_wr) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
            end
        end
    end

endmodule : router_fifo
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fifo
// Description : Directed self-checking bench for router_fifo. Inputs change
//               1 ns after a rising edge and outputs are sampled there too.
//               The data bus is pulled high in the bench, so a released bus
//               reads as 8'hFF. Stimulus bytes avoid that value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fifo;

    localparam logic [7:0] C_FLOAT = 8'hFF;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    tri1  [7:0] data_out;
    logic       full;
    logic       empty;

    int n_chk = 0;
    int n_err = 0;

    router_fifo #(.WIDTH(8), .DEPTH(16)) u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given request lines, then return to idle.
    task automatic tick(input logic w, input logic r, input logic l, input logic [7:0] d);
        write_enb = w;
        read_enb  = r;
        lfd_state = l;
        data_in   = d;
        @(posedge clock);
        #1;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
    endtask

    logic [7:0] pkt [10];

    initial begin
        pkt = '{8'h21, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h5A};

        // ---------------- reset state ----------------
        #12;
        check("rst_empty", {7'd0, empty}, 8'd1);
        check("rst_full", {7'd0, full}, 8'd0);
        check("rst_dout", data_out, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("post_rst_dout", data_out, 8'h00);
        @(posedge clock);
        #1;

        // ---------------- soft reset flush ----------------
        tick(1'b1, 1'b0, 1'b0, 8'h3C);
        check("sr_pre_empty", {7'd0, empty}, 8'd0);
        soft_reset = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 8'h00);   // read loses to soft_reset
        soft_reset = 1'b0;
        check("sr_empty", {7'd0, empty}, 8'd1);
        check("sr_dout_z", data_out, C_FLOAT);

        // ---------------- packet: header 21, 8 payload, parity ----------------
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, (i == 0), pkt[i]);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("pkt_rd%0d", i), data_out, pkt[i]);
            if (i == 2) begin
                // Mid-packet idle: counter is nonzero so the byte is held.
                tick(1'b0, 1'b0, 1'b0, 8'h00);
                check("pkt_hold", data_out, pkt[2]);
            end
        end
        check("pkt_empty", {7'd0, empty}, 8'd1);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        check("pkt_dout_z", data_out, C_FLOAT);

        // ---------------- fill to full, overflow write ignored ----------------
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
            if (i == 14) check("fill15_full", {7'd0, full}, 8'd0);
        end
        check("fill16_full", {7'd0, full}, 8'd1);
        tick(1'b1, 1'b0, 1'b0, 8'hEE);
        check("ovf_full", {7'd0, full}, 8'd1);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("drain_rd%0d", i), data_out, 8'h30 + 8'(i));
        end
        check("drain_empty", {7'd0, empty}, 8'd1);
        tick(1'b0, 1'b1, 1'b0, 8'h00);   // read while empty: nothing read
        check("udf_dout_z", data_out, C_FLOAT);

        // ---------------- simultaneous read+write at empty ----------------
        tick(1'b1, 1'b1, 1'b0, 8'h6B);
        check("rw_empty_empty", {7'd0, empty}, 8'd0);
        check("rw_empty_dout", data_out, C_FLOAT);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("rw_empty_rd", data_out, 8'h6B);

        // ---------------- simultaneous read+write at full, across wrap ----------------
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
        end
        check("rw_full_pre", {7'd0, full}, 8'd1);
        tick(1'b1, 1'b1, 1'b0, 8'h99);
        check("rw_full_rd", data_out, 8'h40);
        check("rw_full_full", {7'd0, full}, 8'd0);
        for (int i = 1; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("rw_full_rd%0d", i), data_out, 8'h40 + 8'(i));
        end
        check("rw_full_empty", {7'd0, empty}, 8'd1);

        // ---------------- asynchronous reset mid-read ----------------
        tick(1'b1, 1'b0, 1'b0, 8'h12);
        tick(1'b1, 1'b0, 1'b0, 8'h34);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        check("ar_pre_dout", data_out, 8'h12);
        read_enb = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("ar_empty", {7'd0, empty}, 8'd1);
        check("ar_full", {7'd0, full}, 8'd0);
        check("ar_dout", data_out, 8'h00);
        read_enb = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 8'h00);   // nothing survived the reset
        check("ar_post_empty", {7'd0, empty}, 8'd1);
        check("ar_post_dout", data_out, C_FLOAT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_router_fifo
`default_nettype wire

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data byte width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of storage words (power of two).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port soft_reset  input  1  synchronous, active-high packet-timeout flush.
REQ-006 SHALL have port write_enb  input  1  write request.
REQ-007 SHALL have port read_enb  input  1  read request.
REQ-008 SHALL have port lfd_state  input  1  marks data_in as a header byte (load-first-data).
REQ-009 SHALL have port data_in  input  WIDTH  byte to store.
REQ-010 SHALL have port data_out  output  WIDTH  registered read data, tri-stateable.
REQ-011 SHALL have port full  output  1  no free word.
REQ-012 SHALL have port empty  output  1  no stored word.

Function
REQ-013 SHALL store each word as WIDTH+1 bits: {lfd_state, data_in}.
REQ-014 SHALL write when write_enb=1 and full=0; data_in stored at write pointer, pointer increments modulo DEPTH.
REQ-015 SHALL read when read_enb=1 and empty=0; stored byte (low WIDTH bits) appears on data_out one clock edge later (registered, latency 1); read pointer increments modulo DEPTH.
REQ-016 SHALL ignore writes while full and reads while empty (no pointer change, no data corruption).
REQ-017 SHALL permit a simultaneous read and write in one cycle, including when full (read succeeds, write blocked) or empty (write succeeds, read blocked).
REQ-018 SHALL use log2(DEPTH)+1-bit read/write pointers; empty = pointers equal; full = low bits equal and MSBs differ; both combinational from pointers.
REQ-019 SHALL keep a 7-bit packet byte counter: on a read of a word whose bit WIDTH (header flag) is 1, load counter with data[7:2]+1 (payload length plus parity).
REQ-020 SHALL decrement the counter on each read of a non-header word while counter is nonzero; never below 0.
REQ-021 SHALL drive data_out to high impedance on the clock edge after the counter is 0 and no read occurs; otherwise hold the last read byte when idle.
REQ-022 SHALL, when soft_reset=1 at a clock edge, clear pointers, counter and memory, and drive data_out to high impedance; soft_reset takes priority over read/write in that cycle.

Reset
REQ-023 SHALL, while resetn=0 (asynchronous), clear both pointers, counter and all memory words, drive data_out to 0; empty=1, full=0.
REQ-024 SHALL resume normal operation on the first rising edge after resetn deasserts; resetn has priority over soft_reset.
REQ-025 SHALL treat reset mid-packet as full discard; no partial packet survives.

Structure
REQ-026 SHALL place WIDTH/DEPTH defaults and the header length field position (bits 7:2) and address field (bits 1:0) in a shared router package used by all router blocks.
REQ-027 SHALL be a single module with no sub-modules; memory inferred as a register array.

Verification
REQ-028 After resetn pulse: empty=1, full=0, data_out=0.
REQ-029 Soft_reset one cycle after data written -> next edge empty=1, data_out=Z.
REQ-030 Write header 8'h21 (length 8, addr 01) with lfd_state=1, then 8 random payload bytes and 1 parity byte, then read continuously -> data_out sequence 21, payload0..7, parity, one cycle after each read edge; counter loaded to 9 on header read, reaches 0 after parity; data_out goes Z on the following idle edge.
REQ-031 16 writes with no read -> full=1 after 16th; 17th write ignored; 16 reads return the first 16 bytes in order, then empty=1.
REQ-032 Read and write both asserted at full with count 16 -> full drops to 0 only momentarily if write blocked; word count becomes 15, correct order maintained across pointer wrap.
REQ-033 Assert resetn=0 between clock edges mid-read -> outputs reset immediately without waiting for a clock edge.
